// File: rtl/ex_alu_seq128_if.sv
// Request/result handshake bundle between the EX issue logic and the 128-bit ALU sequencer.
// The master is the requester; the slave is the sequencer.
interface ex_alu_seq128_if;
    logic         reqValid;
    logic         reqReady;
    logic [3:0]   reqOp;
    logic [127:0] reqRs;
    logic [127:0] reqRt;
    logic [1:0]   reqSrST;
    logic         resValid;
    logic         resReady;
    logic [127:0] resVal;
    logic [1:0]   resSrST;
    logic         resErr;

    modport master (
        output reqValid, reqOp, reqRs, reqRt, reqSrST, resReady,
        input  reqReady, resValid, resVal, resSrST, resErr
    );

    modport slave (
        input  reqValid, reqOp, reqRs, reqRt, reqSrST, resReady,
        output reqReady, resValid, resVal, resSrST, resErr
    );
endinterface

// File: rtl/ex_alu_seq128.sv
// Splits one 128-bit integer op into low/high 64-bit beats on the 1-cycle ALU,
// chaining carry/borrow/equality through the T bit, and returns the 128-bit result.
module ex_alu_seq128 (
    input  logic                 clock,
    input  logic                 reset,
    ex_alu_seq128_if.slave       ifc,
    output logic [63:0]          aluRs,
    output logic [63:0]          aluRt,
    output logic [7:0]           aluIxt,
    output logic [1:0]           aluSrST,
    input  logic [63:0]          aluOutVal,
    input  logic [1:0]           aluOutSrST
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE_LO = 3'd1,
        ISSUE_HI = 3'd2,
        CAPT_HI  = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_ADC   = 4'h2;
    localparam logic [3:0] OP_SBB   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_CMPHS = 4'h9;
    localparam logic [3:0] OP_CMPEQ = 4'hC;

    // ALU op used on each beat; plain ADD/SUB/CMPHS become carry-chained ADC/SBB.
    function automatic logic [3:0] beatOpOf(input logic [3:0] op);
        logic [3:0] beat;
        case (op)
            OP_ADD, OP_ADC:           beat = OP_ADC;
            OP_SUB, OP_SBB, OP_CMPHS: beat = OP_SBB;
            OP_AND, OP_OR, OP_XOR:    beat = op;
            OP_CMPEQ:                 beat = OP_CMPEQ;
            default:                  beat = 4'h0;
        endcase
        return beat;
    endfunction

    function automatic logic isSupported(input logic [3:0] op);
        logic ok;
        case (op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBB, OP_AND, OP_OR, OP_XOR,
            OP_CMPHS, OP_CMPEQ: ok = 1'b1;
            default:            ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t         state_r, nextState_s;
    logic [3:0]     op_r;
    logic [127:0]   rs_r, rt_r;
    logic [1:0]     srST_r;
    logic [63:0]    lowVal_r;
    logic           lowT_r;
    logic           resValid_r, resErr_r;
    logic [127:0]   resVal_r;
    logic [1:0]     resSrST_r;

    logic [3:0]     beatOp_s;
    logic           supported_s, chained_s, lowTin_s, highTin_s, finalT_s, isCompare_s;
    logic           unusedAluS_s;

    assign beatOp_s     = beatOpOf(op_r);
    assign supported_s  = isSupported(op_r);
    assign unusedAluS_s = aluOutSrST[1];

    // Carry-chain selection: which ops pass the low-beat T into the high beat.
    always_comb begin
        chained_s   = 1'b0;
        lowTin_s    = srST_r[0];
        isCompare_s = 1'b0;
        finalT_s    = srST_r[0];
        case (op_r)
            OP_ADD, OP_SUB: begin chained_s = 1'b1; lowTin_s = 1'b0; end
            OP_ADC:         begin chained_s = 1'b1; finalT_s = aluOutSrST[0]; end
            OP_SBB:         begin chained_s = 1'b1; finalT_s = aluOutSrST[0]; end
            OP_CMPHS: begin
                chained_s   = 1'b1;
                lowTin_s    = 1'b0;
                isCompare_s = 1'b1;
                finalT_s    = ~aluOutSrST[0];
            end
            OP_CMPEQ: begin
                isCompare_s = 1'b1;
                finalT_s    = lowT_r & aluOutSrST[0];
            end
            default: begin
                chained_s = 1'b0;
            end
        endcase
        highTin_s = chained_s ? aluOutSrST[0] : srST_r[0];
    end

    // Next-state and ALU beat drive; the ALU bus is quiet outside the issue states.
    always_comb begin
        nextState_s = state_r;
        aluRs       = 64'd0;
        aluRt       = 64'd0;
        aluIxt      = 8'd0;
        aluSrST     = 2'b00;
        case (state_r)
            IDLE: begin
                if (ifc.reqValid) nextState_s = ISSUE_LO;
                else              nextState_s = IDLE;
            end
            ISSUE_LO: begin
                nextState_s = ISSUE_HI;
                if (supported_s) begin
                    aluRs   = rs_r[63:0];
                    aluRt   = rt_r[63:0];
                    aluIxt  = {2'b00, 1'b1, 1'b0, beatOp_s};
                    aluSrST = {srST_r[1], lowTin_s};
                end else begin
                    aluIxt  = 8'd0;
                end
            end
            ISSUE_HI: begin
                nextState_s = CAPT_HI;
                if (supported_s) begin
                    aluRs   = rs_r[127:64];
                    aluRt   = rt_r[127:64];
                    aluIxt  = {2'b00, 1'b1, 1'b0, beatOp_s};
                    aluSrST = {srST_r[1], highTin_s};
                end else begin
                    aluIxt  = 8'd0;
                end
            end
            CAPT_HI: nextState_s = DONE;
            DONE: begin
                if (ifc.resReady) nextState_s = IDLE;
                else              nextState_s = DONE;
            end
            default: nextState_s = IDLE;
        endcase
    end

    // State, request latch, beat capture and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            op_r       <= 4'h0;
            rs_r       <= 128'd0;
            rt_r       <= 128'd0;
            srST_r     <= 2'b00;
            lowVal_r   <= 64'd0;
            lowT_r     <= 1'b0;
            resValid_r <= 1'b0;
            resVal_r   <= 128'd0;
            resSrST_r  <= 2'b00;
            resErr_r   <= 1'b0;
        end else begin
            state_r <= nextState_s;
            case (state_r)
                IDLE: begin
                    if (ifc.reqValid) begin
                        op_r     <= ifc.reqOp;
                        rs_r     <= ifc.reqRs;
                        rt_r     <= ifc.reqRt;
                        srST_r   <= ifc.reqSrST;
                        resErr_r <= 1'b0;
                    end
                end
                ISSUE_HI: begin
                    lowVal_r <= aluOutVal;
                    lowT_r   <= aluOutSrST[0];
                end
                CAPT_HI: begin
                    resValid_r <= 1'b1;
                    resErr_r   <= ~supported_s;
                    resSrST_r  <= {srST_r[1], finalT_s};
                    resVal_r   <= (supported_s && !isCompare_s) ? {aluOutVal, lowVal_r} : 128'd0;
                end
                DONE: begin
                    if (ifc.resReady) resValid_r <= 1'b0;
                end
                default: resValid_r <= 1'b0;
            endcase
        end
    end

    assign ifc.reqReady = (state_r == IDLE) && !reset;
    assign ifc.resValid = resValid_r;
    assign ifc.resVal   = resVal_r;
    assign ifc.resSrST  = resSrST_r;
    assign ifc.resErr   = resErr_r;
endmodule

// File: tb/tb_ex_alu_seq128.sv
// Directed bench for ex_alu_seq128 with a behavioural 64-bit ALU and a 128-bit reference scoreboard.
module tb_ex_alu_seq128;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [63:0]  aluRs, aluRt, aluOutVal;
    logic [7:0]   aluIxt;
    logic [1:0]   aluSrST, aluOutSrST;
    int           checks = 0;
    int           errors = 0;

    typedef struct {
        logic [127:0] val;
        logic [1:0]   srst;
        logic         err;
    } exp_t;
    exp_t sbq[$];

    ex_alu_seq128_if ifc();

    ex_alu_seq128 dut (
        .clock      (clock),
        .reset      (reset),
        .ifc        (ifc.slave),
        .aluRs      (aluRs),
        .aluRt      (aluRt),
        .aluIxt     (aluIxt),
        .aluSrST    (aluSrST),
        .aluOutVal  (aluOutVal),
        .aluOutSrST (aluOutSrST)
    );

    always #5 clock = ~clock;

    // One-cycle registered 64-bit ALU: {T, value}.
    function automatic logic [64:0] aluFn(input logic [7:0] ixt, input logic [63:0] a, input logic [63:0] b,
                                          input logic tin);
        logic [64:0] w;
        w = 65'd0;
        if (ixt[7:4] == 4'b0010) begin
            case (ixt[3:0])
                4'h2: w = {1'b0, a} + {1'b0, b} + {64'd0, tin};
                4'h3: w = {1'b0, a} - {1'b0, b} - {64'd0, tin};
                4'h5: w = {tin, a & b};
                4'h6: w = {tin, a | b};
                4'h7: w = {tin, a ^ b};
                4'hC: w = {(a == b), 64'd0};
                default: w = 65'd0;
            endcase
        end
        return w;
    endfunction

    always @(posedge clock) begin
        {aluOutSrST[0], aluOutVal} <= aluFn(aluIxt, aluRs, aluRt, aluSrST[0]);
        aluOutSrST[1] <= aluSrST[1];
    end

    // 128-bit reference result.
    function automatic exp_t model(input logic [3:0] op, input logic [127:0] a, input logic [127:0] b,
                                   input logic [1:0] srst);
        exp_t e;
        logic [128:0] w;
        e.val = 128'd0; e.srst = srst; e.err = 1'b0;
        case (op)
            4'h0: e.val = a + b;
            4'h1: e.val = a - b;
            4'h2: begin w = {1'b0, a} + {1'b0, b} + {128'd0, srst[0]}; e.val = w[127:0]; e.srst[0] = w[128]; end
            4'h3: begin w = {1'b0, a} - {1'b0, b} - {128'd0, srst[0]}; e.val = w[127:0]; e.srst[0] = w[128]; end
            4'h5: e.val = a & b;
            4'h6: e.val = a | b;
            4'h7: e.val = a ^ b;
            4'h9: e.srst[0] = (a >= b);
            4'hC: e.srst[0] = (a == b);
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic runOp(input string tag, input logic [3:0] op, input logic [127:0] a, input logic [127:0] b,
                         input logic [1:0] srst, input int hold);
        exp_t e;
        exp_t got;
        int   lat;
        e = model(op, a, b, srst);
        lat = 0;
        while (!ifc.reqReady && lat < 20) begin @(posedge clock); #1; lat++; end
        check({tag, " ready"}, {127'd0, ifc.reqReady}, 128'd1);
        ifc.reqValid = 1'b1; ifc.reqOp = op; ifc.reqRs = a; ifc.reqRt = b; ifc.reqSrST = srst;
        sbq.push_back(e);
        @(posedge clock); #1;
        ifc.reqValid = 1'b0;
        check({tag, " busy"}, {127'd0, ifc.reqReady}, 128'd0);
        lat = 0;
        while (!ifc.resValid && lat < 10) begin
            if (e.err) check({tag, " ixt0"}, {120'd0, aluIxt}, 128'd0);
            @(posedge clock); #1; lat++;
        end
        check({tag, " latency"}, lat, 128'd3);
        for (int i = 0; i < hold; i++) begin
            ifc.reqValid = ~ifc.reqValid; ifc.reqOp = 4'h1;
            check({tag, " hold valid"}, {127'd0, ifc.resValid}, 128'd1);
            check({tag, " hold val"}, ifc.resVal, e.val);
            check({tag, " hold ready"}, {127'd0, ifc.reqReady}, 128'd0);
            @(posedge clock); #1;
        end
        ifc.reqValid = 1'b0;
        got = sbq.pop_front();
        check({tag, " val"}, ifc.resVal, got.val);
        check({tag, " srst"}, {126'd0, ifc.resSrST}, {126'd0, got.srst});
        check({tag, " err"}, {127'd0, ifc.resErr}, {127'd0, got.err});
        ifc.resReady = 1'b1;
        @(posedge clock); #1;
        ifc.resReady = 1'b0;
        check({tag, " drained"}, {127'd0, ifc.resValid}, 128'd0);
        check({tag, " idle"}, {127'd0, ifc.reqReady}, 128'd1);
    endtask

    initial begin
        logic [127:0] r1, r2;
        ifc.reqValid = 1'b0; ifc.reqOp = 4'h0; ifc.reqRs = 128'd0; ifc.reqRt = 128'd0;
        ifc.reqSrST = 2'b00; ifc.resReady = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst reqReady", {127'd0, ifc.reqReady}, 128'd0);
        check("rst resValid", {127'd0, ifc.resValid}, 128'd0);
        check("rst resVal", ifc.resVal, 128'd0);
        check("rst resSrST", {126'd0, ifc.resSrST}, 128'd0);
        check("rst resErr", {127'd0, ifc.resErr}, 128'd0);
        reset = 1'b0;
        #1;

        runOp("add carry", 4'h0, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'd1, 2'b01, 0);
        check("add carry literal", ifc.resVal, 128'h1_0000_0000_0000_0000);
        runOp("sbb 0-1", 4'h3, 128'd0, 128'd1, 2'b01, 0);
        check("sbb literal", ifc.resVal, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE);
        runOp("sub 5-3", 4'h1, 128'd5, 128'd3, 2'b10, 0);
        runOp("sub borrow", 4'h1, 128'h1_0000_0000_0000_0000, 128'd1, 2'b01, 0);
        runOp("adc cin", 4'h2, {128{1'b1}}, 128'd0, 2'b01, 0);
        runOp("cmpeq hi diff", 4'hC, 128'h1_1234_5678_9ABC_DEF0, 128'h0_1234_5678_9ABC_DEF0, 2'b01, 0);
        runOp("cmpeq equal", 4'hC, 128'hDEAD_BEEF_0000_0001_1234_5678_9ABC_DEF0,
              128'hDEAD_BEEF_0000_0001_1234_5678_9ABC_DEF0, 2'b10, 0);
        runOp("cmphs ge", 4'h9, 128'h1_0000_0000_0000_0000, 128'h0_FFFF_FFFF_FFFF_FFFF, 2'b00, 0);
        runOp("cmphs lt", 4'h9, 128'h0_FFFF_FFFF_FFFF_FFFF, 128'h1_0000_0000_0000_0000, 2'b01, 0);
        r1 = {$urandom, $urandom, $urandom, $urandom};
        r2 = {$urandom, $urandom, $urandom, $urandom};
        runOp("and", 4'h5, r1, r2, 2'b11, 0);
        runOp("or", 4'h6, r1, r2, 2'b01, 0);
        runOp("xor", 4'h7, r1, r2, 2'b10, 0);
        runOp("add rand", 4'h0, r1, r2, 2'b00, 0);
        runOp("add hold", 4'h0, r2, r1, 2'b11, 5);

        // Abort an op in ISSUE_HI with reset, then confirm recovery.
        ifc.reqValid = 1'b1; ifc.reqOp = 4'h0; ifc.reqRs = r1; ifc.reqRt = r2; ifc.reqSrST = 2'b01;
        @(posedge clock); #1;
        ifc.reqValid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check("abort resValid", {127'd0, ifc.resValid}, 128'd0);
        check("abort reqReady in reset", {127'd0, ifc.reqReady}, 128'd0);
        reset = 1'b0;
        #1;
        check("abort reqReady after", {127'd0, ifc.reqReady}, 128'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            check("abort no result", {127'd0, ifc.resValid}, 128'd0);
        end
        runOp("after abort", 4'h3, r1, r2, 2'b01, 0);

        runOp("bad op", 4'hB, r1, r2, 2'b10, 0);
        runOp("add clears err", 4'h0, 128'd7, 128'd9, 2'b00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
